// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard.
//   NREG_DEF / CNT_W_DEF : default register count and per-register counter width
//   RS_* / RT_*          : source register field positions in the IF/ID word
//   REG_ZERO             : the hardwired-zero register number
package reg_scoreboard_pkg;

    localparam int NREG_DEF  = 32;
    localparam int CNT_W_DEF = 2;
    localparam int REGW      = 5;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    localparam logic [REGW-1:0] REG_ZERO = '0;

    typedef logic [REGW-1:0] regnum_t;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Single pending-write counter for one architectural register.
//   clk_i   : clock
//   rst_n_i : synchronous active-low reset
//   inc_i   : one more write in flight
//   dec_i   : one write retired
//   clr_i   : drop all pending writes (flush)
//   cnt_o   : current pending count
//   zero_o  : count is zero
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Simultaneous inc and dec cancel. The end-stop guards are defensive;
    // the top level already stalls before saturation and gates dec at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per architectural register and
// stalls the ID stage on read-after-write hazards or counter saturation.
//   clk      : clock
//   clrn     : synchronous active-low reset
//   ifid_o   : IF/ID instruction word (rs/rt source fields)
//   id_valid : ID holds a real instruction
//   id_usert : instruction reads rt
//   id_wreg  : instruction writes a register
//   id_wn    : destination register
//   wb_valid : writeback commits a register write
//   wb_wn    : writeback destination
//   flush    : discard all in-flight writes
//   stall    : hold IF/ID this cycle
//   busy     : per-register pending flag
//   wb_err   : sticky, writeback to a register with nothing pending
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [31:0]     ifid_o,
    input  logic            id_valid,
    input  logic            id_usert,
    input  logic            id_wreg,
    input  logic [4:0]      id_wn,
    input  logic            wb_valid,
    input  logic [4:0]      wb_wn,
    input  logic            flush,
    output logic            stall,
    output logic [NREG-1:0] busy,
    output logic            wb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    regnum_t rs;
    regnum_t rt;
    logic    unused_ifid;

    assign rs          = ifid_o[RS_HI:RS_LO];
    assign rt          = ifid_o[RT_HI:RT_LO];
    assign unused_ifid = ^{ifid_o[31:26], ifid_o[15:0]};

    // Register 0 has no storage; its count reads as zero everywhere.
    logic [CNT_W-1:0] cnt [1:NREG-1];
    logic [NREG-1:0]  nz;

    logic [CNT_W-1:0] rs_cnt, rt_cnt, wn_cnt, wb_cnt;
    logic [CNT_W-1:0] rs_eff, rt_eff, wn_eff;
    logic             wb_rel;
    logic             hazard, sat;
    logic             issue, wr_inc;
    logic             wb_err_q, wb_err_d;

    assign wb_rel = wb_valid && (wb_wn != REG_ZERO) && (int'(wb_wn) < NREG);

    always_comb begin
        rs_cnt = '0;
        rt_cnt = '0;
        wn_cnt = '0;
        wb_cnt = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs == REGW'(i))    rs_cnt = cnt[i];
            if (rt == REGW'(i))    rt_cnt = cnt[i];
            if (id_wn == REGW'(i)) wn_cnt = cnt[i];
            if (wb_wn == REGW'(i)) wb_cnt = cnt[i];
        end
    end

    // A writeback landing this cycle releases its register immediately, so
    // the effective count seen by ID already has it subtracted.
    assign rs_eff = rs_cnt - CNT_W'(wb_rel && wb_wn == rs);
    assign rt_eff = rt_cnt - CNT_W'(wb_rel && wb_wn == rt);
    assign wn_eff = wn_cnt - CNT_W'(wb_rel && wb_wn == id_wn);

    assign hazard = ((rs != REG_ZERO) && (rs_eff != '0)) ||
                    (id_usert && (rt != REG_ZERO) && (rt_eff != '0));
    assign sat    = id_wreg && (id_wn != REG_ZERO) && (wn_eff == CNT_MAX);

    assign stall  = clrn && id_valid && !flush && (hazard || sat);
    assign issue  = id_valid && !stall && !flush;
    assign wr_inc = issue && id_wreg && (id_wn != REG_ZERO);

    assign nz[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        logic inc, dec, zero;

        assign inc = wr_inc && (id_wn == REGW'(g));
        assign dec = wb_rel && (wb_wn == REGW'(g)) && !zero;

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i   (clk),
            .rst_n_i (clrn),
            .inc_i   (inc),
            .dec_i   (dec),
            .clr_i   (flush),
            .cnt_o   (cnt[g]),
            .zero_o  (zero)
        );

        assign nz[g] = ~zero;
    end

    assign busy = nz;

    // A flushed writeback is discarded, so it cannot flag an error either.
    assign wb_err_d = wb_err_q || (wb_rel && !flush && (wb_cnt == '0));

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wb_err_q <= 1'b0;
        end else begin
            wb_err_q <= wb_err_d;
        end
    end

    assign wb_err = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    logic        clk;
    logic        clrn;
    logic [31:0] ifid_o;
    logic        id_valid;
    logic        id_usert;
    logic        id_wreg;
    logic [4:0]  id_wn;
    logic        wb_valid;
    logic [4:0]  wb_wn;
    logic        flush;
    logic        stall;
    logic [31:0] busy;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .ifid_o   (ifid_o),
        .id_valid (id_valid),
        .id_usert (id_usert),
        .id_wreg  (id_wreg),
        .id_wn    (id_wn),
        .wb_valid (wb_valid),
        .wb_wn    (wb_wn),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .wb_err   (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic ut, input logic wr, input logic [4:0] wn);
        id_valid = v;
        ifid_o   = {6'd0, rs, rt, 16'h0};
        id_usert = ut;
        id_wreg  = wr;
        id_wn    = wn;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] wn);
        wb_valid = v;
        wb_wn    = wn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn  = 1'b0;
        flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        set_wb(1'b0, 5'd0);

        // reset: stall held low even with an instruction in ID
        set_id(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5);
        tick();
        tick();
        chk("rst_stall", stall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wb_err", wb_err, 0);
        clrn = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        tick();
        chk("post_rst_busy", busy, 0);

        // r0-only instruction never stalls, never marks busy
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
        #1 chk("r0_stall", stall, 0);
        tick();
        chk("r0_busy", busy, 0);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        // writeback to r0 alone leaves wb_err clear
        set_wb(1'b1, 5'd0);
        tick();
        set_wb(1'b0, 5'd0);
        chk("wb0_err", wb_err, 0);

        // RAW on r5: stall until the writeback cycle
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5);
        #1 chk("r5_issue_stall", stall, 0);
        tick();
        chk("r5_busy", busy, 32'h0000_0020);
        set_id(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
        #1 chk("r5_raw_stall", stall, 1);
        tick();
        chk("r5_raw_stall2", stall, 1);
        set_wb(1'b1, 5'd5);
        #1 chk("r5_wb_release", stall, 0);
        tick();
        set_wb(1'b0, 5'd0);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        chk("r5_busy_clr", busy, 0);

        // rt only hazards when id_usert is set
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6);
        tick();
        set_id(1'b1, 5'd0, 5'd6, 1'b0, 1'b0, 5'd0);
        #1 chk("rt_unused_stall", stall, 0);
        id_usert = 1'b1;
        #1 chk("rt_used_stall", stall, 1);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        set_wb(1'b1, 5'd6);
        tick();
        set_wb(1'b0, 5'd0);
        chk("r6_busy_clr", busy, 0);

        // three issues to r7 saturate the counter
        for (int k = 0; k < 3; k++) begin
            set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7);
            #1 chk("r7_issue_stall", stall, 0);
            tick();
        end
        chk("r7_busy", busy, 32'h0000_0080);
        #1 chk("r7_sat_stall", stall, 1);
        set_id(1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0);
        #1 chk("r7_rt_stall", stall, 1);
        // same-cycle writeback drops eff to 2: issue goes ahead, count stays 3
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7);
        set_wb(1'b1, 5'd7);
        #1 chk("r7_sat_release", stall, 0);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        tick();
        tick();
        chk("r7_busy_after2wb", busy, 32'h0000_0080);
        tick();
        set_wb(1'b0, 5'd0);
        chk("r7_busy_after3wb", busy, 0);
        chk("r7_wb_err", wb_err, 0);

        // same-cycle issue and writeback to r9 with one pending
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9);
        tick();
        set_wb(1'b1, 5'd9);
        #1 chk("r9_stall", stall, 0);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        set_wb(1'b0, 5'd0);
        chk("r9_busy_kept", busy, 32'h0000_0200);
        set_wb(1'b1, 5'd9);
        tick();
        set_wb(1'b0, 5'd0);
        chk("r9_busy_clr", busy, 0);
        chk("r9_wb_err", wb_err, 0);

        // writeback to idle r12 sets sticky error
        set_wb(1'b1, 5'd12);
        tick();
        set_wb(1'b0, 5'd0);
        chk("r12_wb_err", wb_err, 1);
        chk("r12_busy", busy, 0);
        tick();
        chk("r12_wb_err_hold", wb_err, 1);
        set_wb(1'b1, 5'd0);
        tick();
        set_wb(1'b0, 5'd0);
        chk("wb0_err_hold", wb_err, 1);

        // flush with pending r3/r4 and ID reading r3
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd4);
        tick();
        chk("r34_busy", busy, 32'h0000_0018);
        set_id(1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 5'd8);
        #1 chk("r3_raw_stall", stall, 1);
        flush = 1'b1;
        #1 chk("flush_stall", stall, 0);
        tick();
        flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        chk("flush_busy", busy, 0);
        chk("flush_wb_err", wb_err, 1);

        // same with reset instead of flush
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd4);
        tick();
        chk("r34_busy2", busy, 32'h0000_0018);
        set_id(1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 5'd8);
        clrn = 1'b0;
        #1 chk("rst_mid_stall", stall, 0);
        tick();
        clrn = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_wb_err", wb_err, 0);
        // pending count was discarded, so this writeback is an error
        set_wb(1'b1, 5'd3);
        tick();
        set_wb(1'b0, 5'd0);
        chk("rst_lost_wb_err", wb_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NREG, default 32, number of architectural registers tracked.
REQ-002 Parameter CNT_W, default 2, width of each per-register pending-write counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clrn  input  1  reset, synchronous, active-low.
REQ-005 ifid_o  input  32  IF/ID instruction word; rs = [25:21], rt = [20:16].
REQ-006 id_valid  input  1  ID holds a real instruction.
REQ-007 id_usert  input  1  instruction reads rt as a source.
REQ-008 id_wreg  input  1  instruction writes a register.
REQ-009 id_wn  input  5  destination register number.
REQ-010 wb_valid  input  1  writeback stage commits a register write this cycle.
REQ-011 wb_wn  input  5  writeback destination register number.
REQ-012 flush  input  1  pipeline flush; discards all in-flight writes.
REQ-013 stall  output  1  hold IF/ID; ID instruction not issued this cycle.
REQ-014 busy  output  NREG  bit i set when counter i is nonzero (registered view).
REQ-015 wb_err  output  1  sticky; writeback hit a register with zero pending count.

Function
REQ-016 Per-register counter cnt[i] of CNT_W bits, unsigned; cnt[0] held at 0 permanently.
REQ-017 rel(r) = wb_valid and wb_wn == r and r != 0; eff(r) = cnt[r] - rel(r).
REQ-018 Hazard: (rs != 0 and eff(rs) != 0) or (id_usert and rt != 0 and eff(rt) != 0); combinational, same cycle.
REQ-019 Saturation: id_wreg and id_wn != 0 and eff(id_wn) == 2^CNT_W - 1 is also a hazard.
REQ-020 stall = id_valid and not flush and (hazard or saturation).
REQ-021 Issue = id_valid and not stall and not flush; on issue with id_wreg and id_wn != 0, cnt[id_wn] increments next edge.
REQ-022 Writeback with rel(wb_wn) and cnt[wb_wn] != 0 decrements cnt[wb_wn] next edge.
REQ-023 Issue and writeback to same register in same cycle: counter unchanged.
REQ-024 Writeback to a register with cnt == 0 (r != 0): counter stays 0, wb_err set and held until reset.
REQ-025 Writeback with wb_wn == 0 ignored; never sets wb_err.
REQ-026 flush: all counters cleared next edge; overrides issue and writeback same cycle; stall forced 0 that cycle.
REQ-027 Counters never wrap; saturation stall (REQ-019) guarantees no overflow.
REQ-028 busy reflects counter state after the edge (one-cycle latency from issue/writeback).
REQ-029 No dependence on previous ifid_o beyond counter state; identical inputs give identical stall.

Reset
REQ-030 clrn low at a rising edge: all counters 0, busy 0, wb_err 0; reset overrides flush, issue, writeback.
REQ-031 During reset stall is driven 0; first edge after clrn high behaves as from empty state.
REQ-032 Reset asserted mid-operation discards all pending counts; later writebacks to those registers set wb_err.

Structure
REQ-033 Shared package holds NREG, CNT_W defaults, field positions RS_HI/RS_LO/RT_HI/RT_LO, and register-zero constant.
REQ-034 One sub-module sb_counter: single CNT_W up/down counter with inc, dec, clr, sync active-low reset, zero flag; instantiated NREG-1 times.
REQ-035 Hazard/stall logic purely combinational in top level; no latches.

Verification
REQ-036 Issue write to r5; next cycle ID reads rs=5 -> stall=1 until cycle wb_valid with wb_wn=5, stall=0 that same cycle.
REQ-037 Three back-to-back issues to r7 with no writeback -> busy[7]=1, cnt=3, fourth issue to r7 stalls on saturation.
REQ-038 Same cycle issue to r9 and writeback r9 with cnt[9]=1 -> cnt[9] stays 1, busy[9] stays 1.
REQ-039 Writeback wb_wn=12 with cnt[12]=0 -> wb_err=1 and remains 1; wb_wn=0 alone -> wb_err unchanged.
REQ-040 Pending r3 and r4, assert flush with id reading r3 -> stall=0, busy=0 next cycle; repeat with clrn low -> same, wb_err cleared.
REQ-041 Instruction with rs=0, rt=0, id_usert=1, id_wn=0 -> never stalls, busy stays 0.
